// File: rtl/sp_pkg.sv
// Shared constants and helpers for the sp_half_adder slice.
// Imported by the top and its lane sub-module.
package sp_pkg;

  localparam int HA_PIPE_DEFAULT = 1;
  localparam int HA_MAX_W = 256;

  function automatic int unsigned ha_popcount(
    input logic [HA_MAX_W-1:0] vec
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < HA_MAX_W; i++) begin
      n += 32'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sp_ha_lane.sv
// Single-bit combinational half adder.
// One instance per lane in sp_half_adder.
module sp_ha_lane
  import sp_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/sp_half_adder.sv
// Lane-parallel half adder with carry summary.
// Optional 1..N output register stages and valid chain.
module sp_half_adder
  import sp_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int PIPE  = HA_PIPE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           sum,
  output logic [WIDTH-1:0]           cout,
  output logic                       out_valid,
  output logic                       carry_any,
  output logic [$clog2(WIDTH+1)-1:0] carry_count
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam int SW    = 2*WIDTH + CNT_W + 2;
  localparam int PD    = (PIPE > 0) ? PIPE : 1;

  logic [WIDTH-1:0] c_sum;
  logic [WIDTH-1:0] c_cout;
  logic             c_any;
  logic [CNT_W-1:0] c_cnt;
  logic [SW-1:0]    st_in;
  logic [SW-1:0]    res;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sp_ha_lane u_lane (
      .a    (a[i]),
      .b    (b[i]),
      .sum  (c_sum[i]),
      .cout (c_cout[i])
    );
  end

  assign c_any = |c_cout;
  assign c_cnt = CNT_W'(ha_popcount(HA_MAX_W'(c_cout)));
  assign st_in = {in_valid, c_any, c_cnt, c_cout, c_sum};

  if (PIPE == 0) begin : g_comb
    assign res = st_in;
  end else begin : g_pipe
    logic [PD-1:0][SW-1:0] pipe;

    // valid rides in the same word, so reset drops it with the data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe <= '0;
      end else begin
        pipe[0] <= st_in;
        for (int s = 1; s < PD; s++) begin
          pipe[s] <= pipe[s-1];
        end
      end
    end

    assign res = pipe[PD-1];
  end

  assign {out_valid, carry_any, carry_count, cout, sum} = res;

endmodule

// File: tb/tb_sp_half_adder.sv
// Bench for sp_half_adder: W1/P1, W8/P1, W8/P2, W8/P0.
// Queue scoreboards for the piped DUTs, direct checks for P0.
module tb_sp_half_adder;

  typedef struct {
    logic [7:0] s;
    logic [7:0] c;
    logic       any;
    logic [3:0] cnt;
    logic       v;
    logic       dc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] s1, c1, n1;
  logic       o1, y1;

  logic       v2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0;
  logic [7:0] s2, c2;
  logic [3:0] n2;
  logic       o2, y2;

  logic       v3 = 1'b0;
  logic [7:0] a3 = '0, b3 = '0;
  logic [7:0] s3, c3;
  logic [3:0] n3;
  logic       o3, y3;

  logic       v0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0;
  logic [7:0] s0, c0;
  logic [3:0] n0;
  logic       o0, y0;

  sp_half_adder #(.WIDTH(1), .PIPE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .a(a1), .b(b1), .sum(s1), .cout(c1),
    .out_valid(o1), .carry_any(y1),
    .carry_count(n1)
  );

  sp_half_adder #(.WIDTH(8), .PIPE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2),
    .a(a2), .b(b2), .sum(s2), .cout(c2),
    .out_valid(o2), .carry_any(y2),
    .carry_count(n2)
  );

  sp_half_adder #(.WIDTH(8), .PIPE(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3),
    .a(a3), .b(b3), .sum(s3), .cout(c3),
    .out_valid(o3), .carry_any(y3),
    .carry_count(n3)
  );

  sp_half_adder #(.WIDTH(8), .PIPE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0),
    .a(a0), .b(b0), .sum(s0), .cout(c0),
    .out_valid(o0), .carry_any(y0),
    .carry_count(n0)
  );

  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  function automatic exp_t model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       v
  );
    exp_t r;
    r.s   = a ^ b;
    r.c   = a & b;
    r.any = |r.c;
    r.cnt = 4'($countones(r.c));
    r.v   = v;
    r.dc  = $isunknown({a, b});
    return r;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  task automatic chkall(
    input string      nm,
    input exp_t       e,
    input logic [7:0] s,
    input logic [7:0] c,
    input logic       any,
    input logic [3:0] cnt,
    input logic       v
  );
    chk({nm, ".valid"}, 32'(v), 32'(e.v));
    if (!e.dc) begin
      chk({nm, ".sum"},  32'(s),   32'(e.s));
      chk({nm, ".cout"}, 32'(c),   32'(e.c));
      chk({nm, ".any"},  32'(any), 32'(e.any));
      chk({nm, ".cnt"},  32'(cnt), 32'(e.cnt));
    end
  endtask

  task automatic chk1(input exp_t e);
    chkall("w1p1", e, {7'b0, s1}, {7'b0, c1},
           y1, {3'b0, n1}, o1);
  endtask

  task automatic step();
    exp_t e;
    q1.push_back(model({7'b0, a1}, {7'b0, b1}, v1));
    q2.push_back(model(a2, b2, v2));
    q3.push_back(model(a3, b3, v3));
    @(posedge clk);
    @(negedge clk);
    e = q1.pop_front();
    chk1(e);
    e = q2.pop_front();
    chkall("w8p1", e, s2, c2, y2, n2, o2);
    e = q3.pop_front();
    chkall("w8p2", e, s3, c3, y3, n3, o3);
  endtask

  task automatic do_reset();
    exp_t z;
    z = model(8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1(z);
    chkall("rst_w8p1", z, s2, c2, y2, n2, o2);
    chkall("rst_w8p2", z, s3, c3, y3, n3, o3);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q1.delete();
    q2.delete();
    q3.delete();
    q3.push_back(z);
  endtask

  task automatic comb(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       v
  );
    a0 = a;
    b0 = b;
    v0 = v;
    #1;
    chkall("w8p0", model(a, b, v),
           s0, c0, y0, n0, o0);
  endtask

  vec_t tv[8];

  initial begin
    tv[0] = '{8'hF0, 8'hCC, 1'b1};
    tv[1] = '{8'h3C, 8'h5A, 1'b0};
    tv[2] = '{8'hFF, 8'hFF, 1'b1};
    tv[3] = '{8'h00, 8'h00, 1'b1};
    tv[4] = '{8'hAA, 8'h55, 1'b1};
    tv[5] = '{8'h81, 8'h81, 1'b0};
    tv[6] = '{8'h7E, 8'h0F, 1'b1};
    tv[7] = '{8'h01, 8'hFF, 1'b1};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      a1 = i[1];
      b1 = i[0];
      v1 = 1'b1;
      a2 = tv[i].a;
      b2 = tv[i].b;
      v2 = tv[i].v;
      a3 = tv[i].a;
      b3 = tv[i].b;
      v3 = tv[i].v;
      step();
    end

    a2 = 'x;
    b2 = 'x;
    v2 = 1'b0;
    a3 = 'x;
    b3 = 'x;
    v3 = 1'b0;
    step();
    step();

    a1 = 1'b1;
    b1 = 1'b1;
    v1 = 1'b1;
    a2 = 8'h33;
    b2 = 8'h0F;
    v2 = 1'b1;
    a3 = 8'h12;
    b3 = 8'h34;
    v3 = 1'b1;
    step();
    a3 = 8'h56;
    b3 = 8'h78;
    step();
    do_reset();

    v3 = 1'b0;
    step();
    step();
    a3 = 8'h9A;
    b3 = 8'hBC;
    v3 = 1'b1;
    step();
    step();
    step();

    comb(8'h01, 8'h01, 1'b1);
    comb(8'hF0, 8'hCC, 1'b0);
    comb(8'hFF, 8'hFF, 1'b1);
    comb(8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    comb(8'h55, 8'hAA, 1'b1);
    comb(8'hC3, 8'h81, 1'b1);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/sp_half_adder.md
Name: sp_half_adder

Overview:
- Clocked, lane-parallel half adder.
- Each lane adds one bit of a to one bit of b, producing sum = a XOR b and cout = a AND b.
- Outputs are registered with a valid qualifier, plus a carry summary (any carry, carry count).
- Used as a leaf arithmetic primitive feeding adder trees and parity/carry logic in the datapath.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (min 1).
- PIPE, 1, output register stages (0 = combinational pass-through, 1 or 2 = that many register stages).

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies a/b this cycle.
- a  in  WIDTH  addend A, one bit per lane.
- b  in  WIDTH  addend B, one bit per lane.
- sum  out  WIDTH  per-lane a XOR b.
- cout  out  WIDTH  per-lane a AND b.
- out_valid  out  1  sum/cout/carry_any/carry_count hold a valid result.
- carry_any  out  1  OR-reduction of cout.
- carry_count  out  $clog2(WIDTH+1)  population count of cout, unsigned.

Behaviour:
- Per lane i:
  - sum[i] = a[i] ^ b[i]
  - cout[i] = a[i] & b[i]
  - Lanes are fully independent; there is no carry propagation between lanes.
- Truth table per lane (a,b -> sum,cout): 00->00, 01->10, 10->10, 11->01.
- carry_any = |cout.
- carry_count = number of set bits in cout, ranging 0..WIDTH. The field is wide enough that it never overflows.
- PIPE=0:
  - All outputs are combinational from the inputs.
  - out_valid = in_valid.
  - clk and rst_n are unused.
- PIPE>=1:
  - Latency is PIPE cycles; one result per cycle, no backpressure.
  - The input sampled at edge N appears at the outputs after edge N+PIPE-1 settles, i.e. with PIPE=1, outputs change on the edge that samples the inputs.
- Data registers load every cycle regardless of in_valid.
- out_valid is in_valid delayed by PIPE cycles. Consumers ignore data when out_valid=0.
- Reset (rst_n=0, asynchronous assertion):
  - All stages clear immediately: sum=0, cout=0, carry_any=0, carry_count=0, out_valid=0.
  - Deassertion is synchronised externally; the first valid output appears PIPE cycles after the first sampled in_valid=1.
- Reset mid-stream: in-flight results are discarded; no partial outputs emerge after reset.
- X on a/b with in_valid=0 must not corrupt out_valid.

Decomposition:
- Shared package sp_pkg:
  - function ha_popcount(vec) for the carry count.
  - localparam CNT_W = $clog2(WIDTH+1) computed in the module.
  - Constant HA_PIPE_DEFAULT = 1.
- One natural sub-module: sp_ha_lane, a purely combinational single-bit half adder (a, b -> sum, cout), instantiated WIDTH times via generate.
- Top handles the reductions, the pipeline registers (generate loop over PIPE) and the valid shift chain.

Test Plan:
- Exhaustive 1-lane, WIDTH=1, PIPE=1, in_valid=1: apply (0,0), (0,1), (1,0), (1,1) on successive cycles -> after 1 cycle each: sum/cout = 0/0, 1/0, 1/0, 0/1; carry_any = 0,0,0,1; carry_count = 0,0,0,1.
- Reset: hold rst_n=0 with a=1, b=1, in_valid=1 -> all outputs 0 asynchronously. Release and clock once -> sum=0, cout=1, out_valid=1.
- Multi-lane WIDTH=8, PIPE=1: a=8'hF0, b=8'hCC -> sum=8'h3C, cout=8'hC0, carry_any=1, carry_count=2. Then a=8'hFF, b=8'hFF -> cout=8'hFF, carry_count=8.
- Valid gating, PIPE=2: in_valid pattern 1,0,1 with distinct data -> out_valid 1,0,1 delayed 2 cycles, each valid result matching its input.
- Mid-stream reset, PIPE=2: assert rst_n=0 for one cycle while two results are in flight -> out_valid stays 0 until new post-reset inputs arrive 2 cycles later.
- PIPE=0 combinational: a=1, b=1 -> sum=0, cout=1 in the same delta without a clock edge; out_valid follows in_valid.
